// File: rtl/oled_i2c_arbiter.sv
// Round-robin arbiter that shares the OLED i2c_master write channel between
// NUM_REQ command sequencers, with a watchdog on i2c_master completion.
module oled_i2c_arbiter #(
  parameter int          NUM_REQ     = 4,
  parameter int          AW          = 8,
  parameter int          DW          = 8,
  parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req,
  output logic [NUM_REQ-1:0]    grant,
  input  logic [NUM_REQ-1:0]    wr_en,
  input  logic [NUM_REQ*AW-1:0] reg_addr,
  input  logic [NUM_REQ*DW-1:0] reg_data,
  output logic [NUM_REQ-1:0]    wr_done,
  output logic [AW-1:0]         i2c_reg_addr,
  output logic [DW-1:0]         i2c_reg_data,
  output logic                  i2c_write_en,
  input  logic                  i2c_done,
  output logic                  busy,
  output logic                  timeout,
  output logic                  dropped
);

  localparam int PW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    WAIT
  } state_t;

  state_t               state_q, state_d;
  logic [PW-1:0]        ptr_q, ptr_d;
  logic [PW-1:0]        owner_q, owner_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   wr_done_q, wr_done_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [DW-1:0]        data_q, data_d;
  logic                 write_en_q, write_en_d;
  logic                 busy_q, busy_d;
  logic                 timeout_q, timeout_d;
  logic                 dropped_q, dropped_d;
  logic [15:0]          cnt_q, cnt_d;

  logic                 found;
  logic [PW-1:0]        sel;
  logic [PW-1:0]        scan_idx;
  logic                 own_live;
  logic                 accept;
  logic [NUM_REQ-1:0]   accept_mask;

  // Scan from ptr upward, wrapping modulo NUM_REQ (valid for non-power-of-two counts).
  always_comb begin
    found    = 1'b0;
    sel      = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      scan_idx = PW'((32'(ptr_q) + k) % NUM_REQ);
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        sel   = scan_idx;
      end
    end
  end

  always_comb begin
    own_live    = (state_q == OWN) && req[owner_q];
    accept      = own_live && wr_en[owner_q];
    accept_mask = accept ? grant_q : '0;
  end

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    grant_d    = grant_q;
    busy_d     = busy_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    wr_done_d  = '0;
    write_en_d = 1'b0;
    timeout_d  = 1'b0;
    dropped_d  = |(wr_en & ~accept_mask);

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = OWN;
          owner_d = sel;
          grant_d = NUM_REQ'(1) << sel;
          busy_d  = 1'b1;
        end
      end
      OWN: begin
        if (!req[owner_q]) begin
          state_d = IDLE;
          grant_d = '0;
          busy_d  = 1'b0;
          ptr_d   = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
        end else if (accept) begin
          state_d    = WAIT;
          addr_d     = reg_addr[owner_q*AW +: AW];
          data_d     = reg_data[owner_q*DW +: DW];
          write_en_d = 1'b1;
          cnt_d      = '0;
        end
      end
      WAIT: begin
        // Completion wins over a coincident watchdog terminal count.
        if (i2c_done) begin
          state_d   = OWN;
          wr_done_d = grant_q;
        end else if ((TIMEOUT_CYC != '0) && (cnt_q == TIMEOUT_CYC)) begin
          state_d   = OWN;
          wr_done_d = grant_q;
          timeout_d = 1'b1;
        end else if (cnt_q != '1) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      grant_q    <= '0;
      wr_done_q  <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      write_en_q <= 1'b0;
      busy_q     <= 1'b0;
      timeout_q  <= 1'b0;
      dropped_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      grant_q    <= grant_d;
      wr_done_q  <= wr_done_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      write_en_q <= write_en_d;
      busy_q     <= busy_d;
      timeout_q  <= timeout_d;
      dropped_q  <= dropped_d;
      cnt_q      <= cnt_d;
    end
  end

  assign grant        = grant_q;
  assign wr_done      = wr_done_q;
  assign i2c_reg_addr = addr_q;
  assign i2c_reg_data = data_q;
  assign i2c_write_en = write_en_q;
  assign busy         = busy_q;
  assign timeout      = timeout_q;
  assign dropped      = dropped_q;

endmodule
